// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//   Single-slave AHB-Lite to APB bridge. Each AHB NONSEQ/SEQ beat that decodes
//   into the bridge window becomes one independent APB transfer. Addresses
//   outside the window get a two-cycle AHB ERROR response.
//   All outputs come straight from flops that one FSM always_ff block updates.
//
// Parameters
//   BASE_NIBBLE  haddr[31:28] value that selects the bridge
//
// Ports
//   hclk, hresetn     clock, synchronous active-low reset
//   hwrite, hreadyin  AHB direction, system HREADY
//   htrans, haddr     AHB transfer type and address
//   hwdata            AHB write data (data phase)
//   prdata, pready    APB read data, completer ready
//   hreadyout, hresp  bridge HREADY, response (1 = ERROR)
//   hrdata            read data returned to the master
//   paddr, pwdata     APB address and write data
//   pwrite, penable   APB direction and enable
//   psel              one-hot APB completer select (3 completers)
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter logic [3:0] BASE_NIBBLE = 4'h8
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  psel
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t     state;
    logic [2:0] sel_q;      // decoded select held across WWAIT
    logic [2:0] dec_sel;
    logic       dec_ok;
    logic       xfer_valid;

    // Address decode: top nibble picks the bridge, next nibble picks the completer.
    always_comb begin
        dec_sel = 3'b000;
        dec_ok  = 1'b0;
        if (haddr[31:28] == BASE_NIBBLE) begin
            case (haddr[27:24])
                4'h0: begin dec_sel = 3'b001; dec_ok = 1'b1; end
                4'h1: begin dec_sel = 3'b010; dec_ok = 1'b1; end
                4'h2: begin dec_sel = 3'b100; dec_ok = 1'b1; end
                default: begin dec_sel = 3'b000; dec_ok = 1'b0; end
            endcase
        end
    end

    // NONSEQ and SEQ are handled identically; IDLE/BUSY never start anything.
    assign xfer_valid = hreadyin && (htrans == 2'b10 || htrans == 2'b11) && (state == IDLE);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= IDLE;
            sel_q     <= 3'b000;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'h0;
            paddr     <= 32'h0;
            pwdata    <= 32'h0;
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            psel      <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    psel      <= 3'b000;
                    penable   <= 1'b0;
                    if (xfer_valid) begin
                        hreadyout <= 1'b0;
                        if (dec_ok) begin
                            paddr  <= haddr;
                            pwrite <= hwrite;
                            sel_q  <= dec_sel;
                            if (hwrite) begin
                                // write data arrives one cycle later; wait for it
                                state <= WWAIT;
                            end else begin
                                psel  <= dec_sel;
                                state <= SETUP;
                            end
                        end else begin
                            hresp <= 1'b1;
                            state <= ERR1;
                        end
                    end
                end
                WWAIT: begin
                    pwdata <= hwdata;
                    psel   <= sel_q;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready low: everything holds, the master keeps stalling
                    if (pready) begin
                        psel      <= 3'b000;
                        penable   <= 1'b0;
                        hreadyout <= 1'b1;
                        if (!pwrite)
                            hrdata <= prdata;
                        state <= IDLE;
                    end
                end
                ERR1: begin
                    // second ERROR cycle releases HREADY so the master sees the response
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    psel      <= 3'b000;
                    penable   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
//   Directed bench for ahb_apb_bridge. Inputs change 1 ns after the rising
//   edge and outputs are checked at the same point. A small APB monitor logs
//   every completed transfer and flags any APB output change during waits.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

    logic        hclk, hresetn, hwrite, hreadyin, pready;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, prdata;
    logic        hreadyout, hresp, pwrite, penable;
    logic [31:0] hrdata, paddr, pwdata;
    logic [2:0]  psel;

    ahb_apb_bridge #(.BASE_NIBBLE(4'h8)) dut (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
        .pready(pready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
        .psel(psel)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } xfer_t;

    xfer_t       log_q[$];
    int          setup_cnt = 0;
    int          unstable  = 0;
    logic        wait_seen = 1'b0;
    logic [2:0]  w_sel;
    logic [31:0] w_addr, w_wdata;
    logic        w_wr;

    int n_chk  = 0;
    int n_fail = 0;

    // APB monitor: samples pre-edge values
    always @(posedge hclk) begin
        if (!hresetn) begin
            wait_seen = 1'b0;
        end else begin
            if (wait_seen && (psel != w_sel || !penable || paddr != w_addr ||
                              pwdata != w_wdata || pwrite != w_wr))
                unstable++;
            wait_seen = 1'b0;
            if (psel != 3'b000 && !penable)
                setup_cnt++;
            if (psel != 3'b000 && penable) begin
                if (pready) begin
                    log_q.push_back('{psel, paddr, pwdata, pwrite});
                end else begin
                    wait_seen = 1'b1;
                    w_sel = psel; w_addr = paddr; w_wdata = pwdata; w_wr = pwrite;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Counts cycles with hreadyout low; optionally raises pready on low cycle rel_at.
    task automatic wait_ready(input int rel_at, output int cnt);
        cnt = 0;
        while (hreadyout == 1'b0 && cnt < 50) begin
            cnt++;
            if (cnt == rel_at) pready = 1'b1;
            tick();
        end
    endtask

    task automatic chk_xfer(input string tag, input int idx, input logic [2:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wr, input logic chk_data);
        xfer_t t;
        t = '{3'b000, 32'h0, 32'h0, 1'b0};
        if (idx < log_q.size()) t = log_q[idx];
        chk({tag, " psel"},  {29'h0, t.sel}, {29'h0, sel});
        chk({tag, " paddr"}, t.addr, addr);
        chk({tag, " pwrite"}, {31'h0, t.write}, {31'h0, wr});
        if (chk_data) chk({tag, " pwdata"}, t.wdata, wdata);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [1:0] tr);
        haddr = a; hwrite = wr; htrans = tr;
        tick();
        htrans = 2'b00;
    endtask

    int lows, n0, s0;
    logic [31:0] bd [4];

    initial begin
        hresetn = 1'b0; hwrite = 1'b0; hreadyin = 1'b1; pready = 1'b1;
        htrans = 2'b00; haddr = 32'h0; hwdata = 32'h0; prdata = 32'h0;
        tick(); tick();

        // reset state
        chk("rst hreadyout", {31'h0, hreadyout}, 32'd1);
        chk("rst hresp",     {31'h0, hresp},     32'd0);
        chk("rst psel",      {29'h0, psel},      32'd0);
        chk("rst penable",   {31'h0, penable},   32'd0);
        chk("rst pwrite",    {31'h0, pwrite},    32'd0);
        chk("rst paddr",     paddr,  32'h0);
        chk("rst pwdata",    pwdata, 32'h0);
        chk("rst hrdata",    hrdata, 32'h0);
        hresetn = 1'b1;
        tick();

        // IDLE and BUSY are ignored; so is a valid-looking phase with hreadyin low
        addr_phase(32'h8000_0000, 1'b1, 2'b00);
        chk("idle htrans hreadyout", {31'h0, hreadyout}, 32'd1);
        chk("idle htrans hresp",     {31'h0, hresp},     32'd0);
        addr_phase(32'h8000_0000, 1'b1, 2'b01);
        chk("busy psel", {29'h0, psel}, 32'd0);
        chk("busy hreadyout", {31'h0, hreadyout}, 32'd1);
        hreadyin = 1'b0;
        addr_phase(32'h8000_0000, 1'b1, 2'b10);
        chk("hreadyin0 hreadyout", {31'h0, hreadyout}, 32'd1);
        hreadyin = 1'b1;
        tick(); tick();
        chk("no xfer yet", log_q.size(), 32'd0);

        // single write
        s0 = setup_cnt;
        addr_phase(32'h8000_0001, 1'b1, 2'b10);
        hwdata = 32'h80;
        wait_ready(0, lows);
        chk("wr lows", lows, 32'd3);
        chk("wr setups", setup_cnt - s0, 32'd1);
        chk("wr count", log_q.size(), 32'd1);
        chk_xfer("wr", 0, 3'b001, 32'h8000_0001, 32'h80, 1'b1, 1'b1);
        chk("wr hresp", {31'h0, hresp}, 32'd0);

        // single read
        prdata = 32'hDEAD_BEEF;
        hwdata = 32'h5555_5555;
        addr_phase(32'h8100_0004, 1'b0, 2'b10);
        chk("rd hrdata before", hrdata, 32'h0);
        wait_ready(0, lows);
        chk("rd lows", lows, 32'd2);
        chk("rd hrdata", hrdata, 32'hDEAD_BEEF);
        chk_xfer("rd", 1, 3'b010, 32'h8100_0004, 32'h0, 1'b0, 1'b0);
        chk("rd pwdata held", pwdata, 32'h80);
        prdata = 32'h0;
        tick();
        chk("rd hrdata held", hrdata, 32'hDEAD_BEEF);

        // read with three pready-low ACCESS cycles
        prdata = 32'h1234_5678;
        pready = 1'b0;
        addr_phase(32'h8200_0008, 1'b0, 2'b10);
        wait_ready(5, lows);
        chk("wait lows", lows, 32'd5);
        chk("wait hrdata", hrdata, 32'h1234_5678);
        chk("wait stable", unstable, 32'd0);
        chk_xfer("wait", 2, 3'b100, 32'h8200_0008, 32'h0, 1'b0, 1'b0);

        // 4-beat INCR write burst, back to back
        bd[0] = 32'h0000_0011; bd[1] = 32'h0000_0022;
        bd[2] = 32'h0000_0033; bd[3] = 32'h0000_0044;
        n0 = log_q.size();
        addr_phase(32'h8000_0001, 1'b1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            hwdata = bd[i];
            if (i < 3) begin
                haddr = 32'h8000_0002 + i; hwrite = 1'b1; htrans = 2'b11;
            end else begin
                htrans = 2'b00;
            end
            wait_ready(0, lows);
            chk($sformatf("burst%0d lows", i), lows, 32'd3);
            if (i < 3) tick();
        end
        chk("burst count", log_q.size() - n0, 32'd4);
        for (int i = 0; i < 4; i++)
            chk_xfer($sformatf("burst%0d", i), n0 + i, 3'b001, 32'h8000_0001 + i,
                     bd[i], 1'b1, 1'b1);

        // decode errors: unused completer nibble, then wrong base nibble
        n0 = log_q.size();
        s0 = setup_cnt;
        addr_phase(32'h8300_0000, 1'b0, 2'b10);
        chk("err1 hresp",     {31'h0, hresp},     32'd1);
        chk("err1 hreadyout", {31'h0, hreadyout}, 32'd0);
        chk("err1 psel",      {29'h0, psel},      32'd0);
        tick();
        chk("err2 hresp",     {31'h0, hresp},     32'd1);
        chk("err2 hreadyout", {31'h0, hreadyout}, 32'd1);
        tick();
        chk("err end hresp",  {31'h0, hresp},     32'd0);
        addr_phase(32'h9000_0000, 1'b1, 2'b10);
        chk("err9 hresp",     {31'h0, hresp},     32'd1);
        chk("err9 hreadyout", {31'h0, hreadyout}, 32'd0);
        tick();
        chk("err9b hresp",     {31'h0, hresp},     32'd1);
        chk("err9b hreadyout", {31'h0, hreadyout}, 32'd1);
        tick();
        chk("err9 end hresp", {31'h0, hresp}, 32'd0);
        chk("err no xfer",  log_q.size() - n0, 32'd0);
        chk("err no setup", setup_cnt - s0, 32'd0);

        // reset during a stalled ACCESS
        n0 = log_q.size();
        pready = 1'b0;
        prdata = 32'hAAAA_5555;
        addr_phase(32'h8000_0010, 1'b0, 2'b10);
        tick();
        chk("abort access penable", {31'h0, penable}, 32'd1);
        hresetn = 1'b0;
        tick();
        chk("abort psel",      {29'h0, psel},      32'd0);
        chk("abort penable",   {31'h0, penable},   32'd0);
        chk("abort hreadyout", {31'h0, hreadyout}, 32'd1);
        chk("abort hrdata",    hrdata, 32'h0);
        hresetn = 1'b1;
        pready = 1'b1;
        addr_phase(32'h8000_0000, 1'b0, 2'b01);
        tick();
        chk("post busy psel",      {29'h0, psel},      32'd0);
        chk("post busy hreadyout", {31'h0, hreadyout}, 32'd1);
        chk("abort no xfer", log_q.size() - n0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
